// File: rtl/seq_det_pkg.sv
// Shared constants for the serial sequence detector: detection modes and legal parameter ranges.
package seq_det_pkg;

  localparam int MODE_NON_OVERLAP = 0;
  localparam int MODE_OVERLAP     = 1;

  localparam int PATW_MIN  = 2;
  localparam int PATW_MAX  = 32;
  localparam int CNT_W_MAX = 32;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter; counts inc pulses, sticky sat once the count reaches all-ones.
// Latency 1 clock from inc; no backpressure, res and clr both zero count and sat.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] nxt;

  assign nxt = cnt + W'(1);

  // sat is set exactly when cnt reaches all-ones, so it doubles as the hold condition
  always_ff @(posedge clk) begin
    if (res || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && !sat) begin
      cnt <= nxt;
      sat <= (nxt == {W{1'b1}});
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with registered 1-cycle match pulse, 1 clock after the accepting edge; in_vld=0 holds state.
// Optional saturating match counter compiled in with SEQDET_COUNT_EN; otherwise match_cnt/cnt_sat are tied low.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   OVERLAP   = 0,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             in_vld,
  input  logic             a,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W = $clog2(PATTERN_W);

  if (PATTERN_W < PATW_MIN || PATTERN_W > PATW_MAX) begin : g_bad_patw
    $error("seq_detector_param: PATTERN_W out of legal range");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cntw
    $error("seq_detector_param: CNT_W out of legal range");
  end
  if (OVERLAP != MODE_NON_OVERLAP && OVERLAP != MODE_OVERLAP) begin : g_bad_mode
    $error("seq_detector_param: OVERLAP must be 0 or 1");
  end

  logic [PATTERN_W-2:0] hist;
  logic [FILL_W-1:0]    fill;
  logic [PATTERN_W-1:0] candidate;
  logic                 accept;
  logic                 full;
  logic                 hit;

  assign candidate = {hist, a};
  assign accept    = in_vld && !clr;
  assign full      = (fill == FILL_W'(PATTERN_W - 1));
  assign hit       = accept && full && (candidate == PATTERN);

  // hist is left alone on clr: with fill at zero its stale contents can never satisfy a match
  always_ff @(posedge clk) begin
    if (res) begin
      hist <= '0;
      fill <= '0;
      y    <= 1'b0;
    end else if (clr) begin
      fill <= '0;
      y    <= 1'b0;
    end else begin
      y <= hit;
      if (accept) begin
        hist <= candidate[PATTERN_W-2:0];
        if (hit && OVERLAP == MODE_NON_OVERLAP) begin
          fill <= '0;
        end else if (!full) begin
          fill <= fill + FILL_W'(1);
        end
      end
    end
  end

`ifdef SEQDET_COUNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .res(res),
    .clr(clr),
    .inc(hit),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule
